// File: rtl/buzz_view.sv
// Quiz-buzzer game view: players race to buzz, the host judges, scores saturate
// at 0..99 and the first player to reach TARGET is latched as the winner.
`timescale 1ns/1ps

module bcd_seg (
  input  logic [3:0] bcd,
  output logic [7:0] seg
);
  // Active-low segments, bit order {dp,g,f,e,d,c,b,a}; any non-BCD code blanks.
  always_comb begin
    case (bcd)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  end
endmodule

module clk_div #(
  parameter int DIV = 100_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)              cnt <= W'(DIV - 1);
    else if (cnt == '0)   cnt <= W'(DIV - 1);
    else                  cnt <= cnt - W'(1);
  end

  assign tick = (cnt == '0);
endmodule

module edge_gen #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);
  logic [W-1:0] sync1, sync2, sync3;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;
endmodule

module seg_tube (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [63:0] seg_bus,
  output logic [7:0]  seg_out,
  output logic [7:0]  seg_en
);
  logic [2:0] sel;

  // seg_out and seg_en are registered from the same sel so they never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel     <= '0;
      seg_out <= 8'hFF;
      seg_en  <= 8'hFF;
    end else begin
      if (tick) sel <= sel + 3'd1;
      seg_out <= seg_bus[{sel, 3'b000} +: 8];
      seg_en  <= ~(8'b1 << sel);
    end
  end
endmodule

// state  | meaning
// IDLE   | view != 1; scores and winner held for the win view
// ARMED  | waiting for the first valid player buzz
// LOCKED | one player holds the answer; waiting for judge or timeout
// WIN    | winner latched, done high
module buzz_view #(
  parameter int TARGET     = 5,
  parameter int ANSWER_MS  = 10_000,
  parameter int BEEP_MS    = 200,
  parameter int CLK_PER_MS = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  view,
  input  logic [2:0]  player_count,
  input  logic [3:0]  player_btn,
  input  logic        judge_ok,
  input  logic        judge_fail,
  output logic [6:0]  player1_score,
  output logic [6:0]  player2_score,
  output logic [6:0]  player3_score,
  output logic [6:0]  player4_score,
  output logic [2:0]  winner,
  output logic        done,
  output logic [7:0]  seg_out,
  output logic [7:0]  seg_en,
  output logic [23:0] led,
  output logic        buzzer
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;
  localparam logic [1:0] S_WIN    = 2'd3;

  localparam int AW = $clog2(ANSWER_MS + 1);
  localparam int BW = $clog2(BEEP_MS + 1);
  localparam logic [3:0] BLANK = 4'hF;

  function automatic logic [3:0] tens_dig(input logic [31:0] v);
    return 4'((v / 32'd10) % 32'd10);
  endfunction

  function automatic logic [3:0] units_dig(input logic [31:0] v);
    return 4'(v % 32'd10);
  endfunction

  logic [1:0]    state;
  logic [2:0]    view_q;
  logic [6:0]    score [4];
  logic [1:0]    lock_idx;
  logic [AW-1:0] ans_left;
  logic [BW-1:0] beep_left;
  logic          ms_tick;
  logic [5:0]    rise;
  logic [3:0]    player_rise;
  logic          ok_p, fail_p;
  logic          active, entry;
  logic [3:0]    valid;
  logic          hit;
  logic [1:0]    hit_idx;
  logic          timeout, judged;
  logic [6:0]    cur_sc, next_sc;
  logic [2:0]    lock_id;
  logic [3:0]    digit [8];
  logic [63:0]   seg_bus;

  clk_div #(.DIV(CLK_PER_MS)) u_ms (
    .clk  (clk),
    .rst  (rst),
    .tick (ms_tick)
  );

  edge_gen #(.W(6)) u_edge (
    .clk  (clk),
    .rst  (rst),
    .din  ({judge_fail, judge_ok, player_btn}),
    .rise (rise)
  );

  assign player_rise = rise[3:0];
  assign ok_p        = rise[4];
  assign fail_p      = rise[5];
  assign active      = (view == 3'd1);
  assign entry       = active && (view_q != 3'd1);
  assign lock_id     = {1'b0, lock_idx} + 3'd1;

  // Lowest-numbered valid buzz wins a tie, so scan from the top down.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    for (int k = 0; k < 4; k++) valid[k] = player_rise[k] && (3'(k) < player_count);
    for (int k = 3; k >= 0; k--) begin
      if (valid[k]) begin
        hit     = 1'b1;
        hit_idx = 2'(k);
      end
    end
  end

  // Down-counter terminal count: the tick taking it 1 -> 0 is elapsed == ANSWER_MS.
  assign timeout = ms_tick && (ans_left == AW'(1));
  assign judged  = ok_p || fail_p || timeout;
  assign cur_sc  = score[lock_idx];

  always_comb begin
    if (ok_p)               next_sc = (cur_sc >= 7'd99) ? 7'd99 : cur_sc + 7'd1;
    else if (cur_sc == '0)  next_sc = '0;
    else                    next_sc = cur_sc - 7'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      view_q    <= '0;
      lock_idx  <= '0;
      winner    <= '0;
      ans_left  <= '0;
      beep_left <= '0;
      for (int k = 0; k < 4; k++) score[k] <= '0;
    end else begin
      view_q <= view;
      if (ms_tick && beep_left != '0) beep_left <= beep_left - BW'(1);
      if (ms_tick && ans_left != '0)  ans_left  <= ans_left - AW'(1);
      if (!active) begin
        state <= S_IDLE;
      end else if (entry) begin
        state     <= S_ARMED;
        lock_idx  <= '0;
        winner    <= '0;
        ans_left  <= '0;
        beep_left <= '0;
        for (int k = 0; k < 4; k++) score[k] <= '0;
      end else begin
        case (state)
          S_ARMED: begin
            if (hit) begin
              lock_idx  <= hit_idx;
              ans_left  <= AW'(ANSWER_MS);
              beep_left <= BW'(BEEP_MS);
              state     <= S_LOCKED;
            end
          end
          S_LOCKED: begin
            if (judged) begin
              score[lock_idx] <= next_sc;
              if (next_sc == 7'(TARGET)) begin
                winner <= lock_id;
                state  <= S_WIN;
              end else begin
                state <= S_ARMED;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign player1_score = score[0];
  assign player2_score = score[1];
  assign player3_score = score[2];
  assign player4_score = score[3];
  assign done          = (state == S_WIN);
  assign buzzer        = (beep_left != '0) && ((state == S_ARMED) || (state == S_LOCKED));

  always_comb begin
    led = '0;
    if (state == S_LOCKED || state == S_WIN) led[3:0] = 4'b1 << lock_idx;
    led[23] = done;
  end

  always_comb begin
    for (int k = 0; k < 8; k++) digit[k] = BLANK;
    case (state)
      S_ARMED: begin
        for (int k = 0; k < 4; k++)
          if (3'(k) < player_count) digit[k] = units_dig(32'(score[k]));
      end
      S_LOCKED: begin
        digit[0] = {1'b0, lock_id};
        digit[4] = tens_dig(32'(ans_left) / 32'd1000);
        digit[5] = units_dig(32'(ans_left) / 32'd1000);
        digit[6] = tens_dig(32'(cur_sc));
        digit[7] = units_dig(32'(cur_sc));
      end
      S_WIN: begin
        digit[0] = {1'b0, winner};
        digit[6] = tens_dig(32'(cur_sc));
        digit[7] = units_dig(32'(cur_sc));
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < 8; g++) begin : g_dig
    bcd_seg u_bcd (
      .bcd (digit[g]),
      .seg (seg_bus[8*g +: 8])
    );
  end

  seg_tube u_tube (
    .clk     (clk),
    .rst     (rst),
    .tick    (ms_tick),
    .seg_bus (seg_bus),
    .seg_out (seg_out),
    .seg_en  (seg_en)
  );
endmodule

// File: doc/buzz_view.md
# buzz_view

Quiz-buzzer game view that produces the per-player scores and the winner index consumed by the results (win) view. It is active while `view == 1`. Players race to press their buttons, the host judges each answer, and the block keeps saturating scores. When a player reaches `TARGET`, it latches the winner and raises `done` so the top level switches `view` to 2. It drives its own seven-segment digits, LEDs and buzzer, using the shared `clk_div`, `edge_gen`, `seg_tube` and `bcd_seg` blocks.

## Interface
- `TARGET`, 5 — score that ends the game (1..99).
- `ANSWER_MS`, 10_000 — answer window in ms after a lock; expiry counts as a wrong answer.
- `BEEP_MS`, 200 — buzzer on-time after a lock.
- `CLK_PER_MS`, 100_000 — `clk` cycles per ms (100 MHz board clock).
- `clk` input 1 — system clock.
- `rst` input 1 — synchronous, active-high reset.
- `view` input 3 — current view; the block runs only when `view == 1`.
- `player_count` input 3 — number of players, 2..4; buttons of higher-numbered players are ignored.
- `player_btn` input 4 — raw player buttons, bit k = player k+1, active high, asynchronous.
- `judge_ok` input 1 — raw host button, "correct".
- `judge_fail` input 1 — raw host button, "wrong".
- `player1_score`..`player4_score` output 7 each — current scores, 0..99.
- `winner` output 3 — winning player 1..4; 0 while no winner.
- `done` output 1 — level, high in state WIN.
- `seg_out`, `seg_en` output 8 each — `seg_tube` drive.
- `led` output 24 — status LEDs.
- `buzzer` output 1 — beep.

## Operation
- **Input conditioning.**
  - All raw buttons pass through a 2-FF synchronizer, then a rising-edge detector.
  - Only the one-cycle edge pulses are used in the state logic.
  - Holding a button generates no further events.
- **States:** IDLE, ARMED, LOCKED, WIN.
- **IDLE.**
  - Entered on `rst` and whenever `view != 1`.
  - Scores and `winner` HOLD in IDLE, so the win view can read them.
- **Entering ARMED.** On the cycle `view` changes to 1 (previous-cycle `view != 1`), the block clears all scores, `winner` and the ms counters, and goes to ARMED.
- **ARMED.**
  - The first valid player edge locks that player; `locked_id` = 1..4; go to LOCKED.
  - A player edge is valid only if its index ≤ `player_count`.
  - Simultaneous edges: the lowest index wins.
  - Judge edges are ignored in ARMED.
- **LOCKED.**
  - Player edges are ignored.
  - `judge_ok` edge: the locked player's score +1, saturating at 99.
  - `judge_fail` edge, or ms counter reaching `ANSWER_MS`: the locked player's score −1, floored at 0.
  - Both judge edges in the same cycle: `judge_ok` has priority.
  - After a judgement, if the new score == `TARGET`, set `winner = locked_id` and go to WIN. Otherwise return to ARMED.
- **WIN.**
  - `done = 1`. All inputs other than `rst`/`view` are ignored.
  - Leaving `view == 1` goes to IDLE, with scores and `winner` held.
- **Display.**
  - IDLE: all digits blank (0xFF).
  - ARMED: digits 0..3 show scores of players 1..`player_count` (units digit mod 10); the rest blank.
  - LOCKED: digit 0 = `locked_id`; digits 4-5 = remaining whole seconds of the window, (`ANSWER_MS` − elapsed)/1000, 2 BCD digits; digits 6-7 = locked player's score, tens and units.
  - WIN: digit 0 = `winner`; digits 6-7 = winner score; the rest blank.
- **LEDs.**
  - `led[3:0]` = one-hot of `locked_id` in LOCKED, all-ones for the winner bit in WIN, otherwise 0.
  - `led[23]` = `done`.
  - Other bits 0.
- **Buzzer.**
  - High for `BEEP_MS` starting the cycle after entering LOCKED.
  - A new lock restarts the beep.
  - Forced low outside ARMED/LOCKED.

## Timing
- **Reset values:** state IDLE; all scores 0; `winner` 0; `done` 0; `led` 0; `buzzer` 0; all digits blank.
- **Button latency:** raw edge to state change is 3 `clk` cycles (2 sync + 1 register).
- **Score update:** score outputs change on the same edge that leaves LOCKED. `winner` and `done` update on that same edge.
- **Timebase:** the ms timebase is free-running. The answer counter resets to 0 on entry to LOCKED and counts ms ticks. Timeout fires on the tick where the count reaches `ANSWER_MS`, so the window is `ANSWER_MS` ± 1 ms.
- **Synchronous reset priority:** `rst` beats everything. Reset mid-LOCKED clears everything with no score change.
- **View change priority:** a `view` change away from 1 takes priority over judging in the same cycle, so no score change occurs.

## Test plan
- **Reset and entry:** assert `rst` with `view = 1` -> all outputs 0. Deassert, then `view` 0->1 with `player_count = 2` -> ARMED, digits 0-1 show "0".
- **Normal round:** press btn[1] then `judge_ok` -> `player2_score = 1`, state ARMED, buzzer high for 200 ms after the lock.
- **Simultaneous buzz and invalid player:** btn[3] and btn[2] in the same cycle with `player_count = 3` -> player 3 locks. btn[3] alone with `player_count = 3` -> ignored.
- **Floor, timeout and judge priority:**
  - `judge_fail` at score 0 -> stays 0.
  - No judge for 10 000 ms (timeout) -> score −1 (floored) and back to ARMED.
  - `judge_ok` and `judge_fail` in the same cycle -> +1.
- **Win:** player 1 answers correctly 5 times with `TARGET = 5` -> `winner = 1`, `done = 1`, `led[23] = 1`. Then `view -> 2` -> state IDLE, `player1_score` still 5, `winner` still 1.
- **Re-entry clears:** `view` 2->1 -> all scores 0, `winner = 0`, `done = 0`.
